// File: rtl/pc_bus_ctrl.sv
// Purpose : 8088 local-bus to PC system-bus controller. Latches the multiplexed
//           address on ALE, turns CPU rd_n/wr_n into MEMR/MEMW/IOR/IOW strobes,
//           and holds the CPU in wait states from per-space counts, sys_rdy and a watchdog.
// Latency : strobe and sys_addr/sys_dout appear 1 cycle after the CPU edge is sampled;
//           read data is captured on the completing edge; strobes drop 1 cycle after rd_n/wr_n rise.
// Backpres: sys_rdy=0 stretches the command phase (ready=0) until sys_rdy=1 or TIMEOUT stall cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   ale, ad_in, a_hi    CPU address latch enable, sampled AD[7:0], A[19:8]
//   rd_n, wr_n, iom     CPU read/write strobes and I/O-vs-memory select
//   den_n               CPU data enable; gates ad_oe on reads
//   ad_out, ad_oe       read data returned to the CPU and its output enable
//   ready               CPU ready (low inserts wait states)
//   sys_addr, sys_dout  latched system address and write data
//   sys_din, sys_rdy    system read data and device ready
//   memr_n..iow_n       system bus strobes (at most one low)
//   bus_err             one-cycle pulse on protocol error or timeout
module pc_bus_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ale,
  input  logic [7:0]  ad_in,
  input  logic [11:0] a_hi,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        iom,
  input  logic        den_n,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        ready,
  output logic [19:0] sys_addr,
  output logic [7:0]  sys_dout,
  input  logic [7:0]  sys_din,
  output logic        memr_n,
  output logic        memw_n,
  output logic        ior_n,
  output logic        iow_n,
  input  logic        sys_rdy,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CMD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LP_MEM_WAIT = 4'(MEM_WAIT);
  localparam logic [3:0] LP_IO_WAIT  = 4'(IO_WAIT);
  // Timeout fires on the TIMEOUT-th stall cycle, i.e. when the count already
  // holds TIMEOUT-1 and the device is still not ready.
  localparam logic [7:0] LP_TO_LAST  = 8'(TIMEOUT - 1);

  // Strobe vector ordering: {memr_n, memw_n, ior_n, iow_n}
  localparam logic [3:0] LP_STRB_NONE = 4'b1111;

  state_t      r_state;
  logic        r_iom;
  logic        r_rd;
  logic [3:0]  r_wait_cnt;
  logic [7:0]  r_to_cnt;
  logic [3:0]  r_strb_n;
  logic        r_bus_err;
  logic [19:0] r_sys_addr;
  logic [7:0]  r_sys_dout;
  logic [7:0]  r_ad_out;

  state_t      w_state;
  logic        w_iom;
  logic        w_rd;
  logic [3:0]  w_wait_cnt;
  logic [7:0]  w_to_cnt;
  logic [3:0]  w_strb_n;
  logic        w_bus_err;
  logic [19:0] w_sys_addr;
  logic [7:0]  w_sys_dout;
  logic [7:0]  w_ad_out;

  logic        w_cmd_done;
  logic        w_stall;
  logic        w_timeout;
  logic [3:0]  w_strb_sel;

  // Completion and stall conditions only matter while in CMD.
  assign w_cmd_done = (r_wait_cnt == 4'd0) && sys_rdy;
  assign w_stall    = (r_wait_cnt == 4'd0) && !sys_rdy;
  assign w_timeout  = w_stall && (r_to_cnt == LP_TO_LAST);

  // Strobe chosen from the latched space and the CPU direction being sampled.
  always_comb begin
    w_strb_sel = LP_STRB_NONE;
    case ({r_iom, !rd_n})
      2'b01:   w_strb_sel = 4'b0111;  // memory read
      2'b00:   w_strb_sel = 4'b1011;  // memory write
      2'b11:   w_strb_sel = 4'b1101;  // I/O read
      default: w_strb_sel = 4'b1110;  // I/O write
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_iom      = r_iom;
    w_rd       = r_rd;
    w_wait_cnt = r_wait_cnt;
    w_to_cnt   = r_to_cnt;
    w_strb_n   = r_strb_n;
    w_bus_err  = 1'b0;
    w_sys_addr = r_sys_addr;
    w_sys_dout = r_sys_dout;
    w_ad_out   = r_ad_out;

    if (ale) begin
      // ALE always wins: latch the new address from any state. Arriving
      // mid-command it aborts the cycle and is reported as an error.
      w_sys_addr = {a_hi, ad_in};
      w_iom      = iom;
      w_state    = ADDR;
      if ((r_state == CMD) || (r_state == DONE)) begin
        w_bus_err = 1'b1;
        w_strb_n  = LP_STRB_NONE;
      end
    end else begin
      case (r_state)
        ADDR: begin
          if (!rd_n && !wr_n) begin
            // Both strobes low is illegal: flag it and keep waiting in ADDR.
            w_bus_err = 1'b1;
          end else if (rd_n ^ wr_n) begin
            w_state    = CMD;
            w_rd       = !rd_n;
            w_strb_n   = w_strb_sel;
            w_wait_cnt = r_iom ? LP_IO_WAIT : LP_MEM_WAIT;
            w_to_cnt   = 8'd0;
            if (rd_n) begin
              w_sys_dout = ad_in;
            end
          end
        end
        CMD: begin
          if (w_cmd_done) begin
            w_state = DONE;
            if (r_rd) begin
              w_ad_out = sys_din;
            end
          end else if (w_timeout) begin
            // Forced completion: reads return all-ones like an empty bus.
            w_state   = DONE;
            w_bus_err = 1'b1;
            if (r_rd) begin
              w_ad_out = 8'hFF;
            end
          end else begin
            if (r_wait_cnt != 4'd0) begin
              w_wait_cnt = r_wait_cnt - 4'd1;
            end
            if (w_stall) begin
              w_to_cnt = r_to_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          if (rd_n && wr_n) begin
            w_strb_n = LP_STRB_NONE;
            w_state  = IDLE;
          end
        end
        default: begin
          // IDLE: CPU strobes without a preceding ALE are ignored.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_iom      <= 1'b0;
      r_rd       <= 1'b0;
      r_wait_cnt <= 4'd0;
      r_to_cnt   <= 8'd0;
      r_strb_n   <= LP_STRB_NONE;
      r_bus_err  <= 1'b0;
      r_sys_addr <= 20'd0;
      r_sys_dout <= 8'd0;
      r_ad_out   <= 8'd0;
    end else begin
      r_state    <= w_state;
      r_iom      <= w_iom;
      r_rd       <= w_rd;
      r_wait_cnt <= w_wait_cnt;
      r_to_cnt   <= w_to_cnt;
      r_strb_n   <= w_strb_n;
      r_bus_err  <= w_bus_err;
      r_sys_addr <= w_sys_addr;
      r_sys_dout <= w_sys_dout;
      r_ad_out   <= w_ad_out;
    end
  end

  assign memr_n   = r_strb_n[3];
  assign memw_n   = r_strb_n[2];
  assign ior_n    = r_strb_n[1];
  assign iow_n    = r_strb_n[0];
  assign bus_err  = r_bus_err;
  assign sys_addr = r_sys_addr;
  assign sys_dout = r_sys_dout;
  assign ad_out   = r_ad_out;

  // ready follows sys_rdy combinationally in CMD so the CPU sees the device
  // release in the same cycle it completes; the state reset makes it 1 at once.
  assign ready = (r_state != CMD) || w_cmd_done;

  // Drive the CPU bus only for a finished read and only while den_n is low.
  assign ad_oe = (r_state == DONE) && r_rd && !den_n;

endmodule

// File: tb/tb_pc_bus_ctrl.sv
module tb_pc_bus_ctrl;
  localparam int MW = 0;
  localparam int IW = 1;
  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ale = 1'b0;
  logic [7:0]  ad_in = 8'd0;
  logic [11:0] a_hi = 12'd0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        iom = 1'b0;
  logic        den_n = 1'b1;
  logic [7:0]  sys_din = 8'd0;
  logic        sys_rdy = 1'b1;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic        ready;
  logic [19:0] sys_addr;
  logic [7:0]  sys_dout;
  logic        memr_n, memw_n, ior_n, iow_n;
  logic        bus_err;

  always #5 clk = ~clk;

  pc_bus_ctrl #(.MEM_WAIT(MW), .IO_WAIT(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ale(ale), .ad_in(ad_in), .a_hi(a_hi),
    .rd_n(rd_n), .wr_n(wr_n), .iom(iom), .den_n(den_n),
    .ad_out(ad_out), .ad_oe(ad_oe), .ready(ready),
    .sys_addr(sys_addr), .sys_dout(sys_dout), .sys_din(sys_din),
    .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n),
    .sys_rdy(sys_rdy), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  strb;
    logic [19:0] addr;
    logic        wr;
    logic [7:0]  wd;
  } strb_exp_t;

  strb_exp_t   q_strb[$];  // expected strobe launches
  int          q_rdy[$];   // expected lengths of ready-low runs
  logic [19:0] q_err[$];   // expected sys_addr seen with each bus_err pulse
  logic [7:0]  q_dat[$];   // expected ad_out at each ad_oe rise

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Strobe vector {memr_n,memw_n,ior_n,iow_n} selected by space and direction.
  function automatic logic [3:0] strb_code(input logic io, input logic is_rd);
    if (!io && is_rd)  return 4'b0111;
    if (!io && !is_rd) return 4'b1011;
    if (io && is_rd)   return 4'b1101;
    return 4'b1110;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [3:0] s;
    logic [3:0] prev_s;
    logic       ale_s, rdn_s, wrn_s, rel, prev_oe;
    int         run;
    strb_exp_t  e;
    prev_s = 4'hF; ale_s = 1'b0; rdn_s = 1'b1; wrn_s = 1'b1; run = 0; prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      s = {memr_n, memw_n, ior_n, iow_n};
      if (!rst_n) begin
        prev_s = 4'hF; run = 0; prev_oe = 1'b0;
      end else begin
        if (s != 4'hF) chk("one_strobe_low", 32'($countones(~s)), 32'd1);
        if (prev_s != 4'hF) begin
          // An active strobe only ends after ALE or both CPU strobes high were sampled.
          rel = ale_s || (rdn_s && wrn_s);
          chk("strobe_hold_release", 32'(s), 32'(rel ? 4'hF : prev_s));
        end else if (s != 4'hF) begin
          chk("strobe_launch_cause", 32'({ale_s, rdn_s ^ wrn_s}), 32'(2'b01));
          if (q_strb.size() == 0) begin
            chk("unexpected_strobe", 32'(s), 32'hF);
          end else begin
            e = q_strb.pop_front();
            chk("strobe_kind", 32'(s), 32'(e.strb));
            chk("sys_addr", 32'(sys_addr), 32'(e.addr));
            if (e.wr) chk("sys_dout", 32'(sys_dout), 32'(e.wd));
          end
        end
        if (!ready) begin
          run++;
        end else if (run > 0) begin
          if (q_rdy.size() == 0) chk("unexpected_ready_low", 32'(run), 32'd0);
          else chk("ready_low_cycles", 32'(run), 32'(q_rdy.pop_front()));
          run = 0;
        end
        if (bus_err) begin
          if (q_err.size() == 0) chk("unexpected_bus_err", 32'(bus_err), 32'd0);
          else chk("bus_err_addr", 32'(sys_addr), 32'(q_err.pop_front()));
        end
        if (ad_oe) chk("ad_oe_with_den", 32'(den_n), 32'd0);
        if (ad_oe && !prev_oe) begin
          if (q_dat.size() == 0) chk("unexpected_ad_oe", 32'(ad_oe), 32'd0);
          else chk("ad_out", 32'(ad_out), 32'(q_dat.pop_front()));
        end
        prev_oe = ad_oe;
        prev_s  = s;
      end
      ale_s = ale; rdn_s = rd_n; wrn_s = wr_n;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic do_ale(input logic io, input logic [19:0] addr, input logic early, input logic is_rd);
    ale = 1'b1; iom = io; a_hi = addr[19:8]; ad_in = addr[7:0];
    if (early) begin
      if (is_rd) rd_n = 1'b0; else wr_n = 1'b0;
    end
    tick();
    ale = 1'b0;
  endtask

  // Runs a command from ADDR; expected results follow from the wait count for the
  // space, the number of cycles the device holds sys_rdy low, and the timeout.
  task automatic do_cmd(input logic io, input logic is_rd, input logic [19:0] addr,
                        input logic [7:0] wd, input logic [7:0] rdat, input int stall);
    int w;
    int eff;
    w   = io ? IW : MW;
    eff = (stall < TO) ? stall : TO;
    q_strb.push_back('{strb: strb_code(io, is_rd), addr: addr, wr: !is_rd, wd: wd});
    if (w + eff > 0) q_rdy.push_back(w + eff);
    if (stall >= TO) q_err.push_back(addr);
    if (is_rd) repeat (2) q_dat.push_back((stall >= TO) ? 8'hFF : rdat);
    sys_din = rdat;
    den_n   = 1'b0;
    sys_rdy = (w + stall == 0);
    if (is_rd) rd_n = 1'b0;
    else begin wr_n = 1'b0; ad_in = wd; end
    tick();
    repeat (w + stall) tick();
    sys_rdy = 1'b1;
    tick();
    if (is_rd) begin
      tick();
      den_n = 1'b1;
      tick();
      den_n = 1'b0;
      tick();
    end else begin
      tick();
    end
    rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1;
    tick();
  endtask

  task automatic do_both_err(input logic io, input logic [19:0] addr);
    do_ale(io, addr, 1'b0, 1'b0);
    rd_n = 1'b0; wr_n = 1'b0;
    q_err.push_back(addr);
    tick();
    rd_n = 1'b1; wr_n = 1'b1;
    tick();
  endtask

  task automatic do_abort(input logic [19:0] a1, input logic [7:0] wd,
                          input logic [19:0] a2, input logic io2);
    do_ale(1'b0, a1, 1'b0, 1'b0);
    q_strb.push_back('{strb: 4'b1011, addr: a1, wr: 1'b1, wd: wd});
    sys_rdy = 1'b1; wr_n = 1'b0; ad_in = wd;
    tick();
    ale = 1'b1; iom = io2; a_hi = a2[19:8]; ad_in = a2[7:0]; wr_n = 1'b1;
    q_err.push_back(a2);
    tick();
    ale = 1'b0;
  endtask

  task automatic idle_noise();
    rd_n = 1'b0; tick(); tick(); rd_n = 1'b1; tick();
    wr_n = 1'b0; tick(); wr_n = 1'b1; tick();
  endtask

  initial begin : stim
    logic        io, is_rd, early;
    logic [19:0] addr, addr2;
    logic [7:0]  wd, rdat;
    int          sel, stall;

    tick();
    chk("rst_memr_n", 32'(memr_n), 32'd1);
    chk("rst_memw_n", 32'(memw_n), 32'd1);
    chk("rst_ior_n", 32'(ior_n), 32'd1);
    chk("rst_iow_n", 32'(iow_n), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ad_oe", 32'(ad_oe), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_sys_addr", 32'(sys_addr), 32'd0);
    chk("rst_sys_dout", 32'(sys_dout), 32'd0);
    chk("rst_ad_out", 32'(ad_out), 32'd0);
    rst_n = 1'b1;
    tick();

    idle_noise();
    do_ale(1'b0, 20'hF0012, 1'b0, 1'b1);
    do_cmd(1'b0, 1'b1, 20'hF0012, 8'h00, 8'hA5, 0);
    do_ale(1'b1, 20'h003F8, 1'b0, 1'b0);
    do_cmd(1'b1, 1'b0, 20'h003F8, 8'h5A, 8'h00, 0);
    do_ale(1'b0, 20'h12345, 1'b0, 1'b1);
    do_cmd(1'b0, 1'b1, 20'h12345, 8'h00, 8'h3C, 5);
    do_ale(1'b1, 20'h00060, 1'b0, 1'b1);
    do_cmd(1'b1, 1'b1, 20'h00060, 8'h00, 8'h77, TO);
    do_both_err(1'b0, 20'hABCDE);
    do_cmd(1'b0, 1'b1, 20'hABCDE, 8'h00, 8'h81, 1);
    do_abort(20'h40000, 8'hC3, 20'h50505, 1'b0);
    do_cmd(1'b0, 1'b1, 20'h50505, 8'h00, 8'h19, 0);
    do_ale(1'b0, 20'h0BEEF, 1'b1, 1'b1);
    do_cmd(1'b0, 1'b1, 20'h0BEEF, 8'h00, 8'hE7, 2);

    for (int i = 0; i < 60; i++) begin
      sel   = int'($urandom_range(0, 9));
      io    = 1'($urandom_range(0, 1));
      is_rd = 1'($urandom_range(0, 1));
      early = ($urandom_range(0, 4) == 0);
      addr  = 20'($urandom);
      addr2 = 20'($urandom);
      wd    = 8'($urandom);
      rdat  = 8'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 1, TO + 1))
                                          : int'($urandom_range(0, 3));
      if (sel == 0) begin
        do_both_err(io, addr);
        do_cmd(io, is_rd, addr, wd, rdat, stall);
      end else if (sel == 1) begin
        do_abort(addr, wd, addr2, io);
        do_cmd(io, is_rd, addr2, wd, rdat, stall);
      end else begin
        do_ale(io, addr, early, is_rd);
        do_cmd(io, is_rd, addr, wd, rdat, stall);
      end
    end

    // Reset in the middle of a stalled memory read.
    do_ale(1'b0, 20'h77777, 1'b0, 1'b1);
    q_strb.push_back('{strb: 4'b0111, addr: 20'h77777, wr: 1'b0, wd: 8'h00});
    sys_rdy = 1'b0; den_n = 1'b0; rd_n = 1'b0;
    tick();
    tick();
    chk("pre_reset_memr_n", 32'(memr_n), 32'd0);
    chk("pre_reset_ready", 32'(ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_memr_n", 32'(memr_n), 32'd1);
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_ad_oe", 32'(ad_oe), 32'd0);
    chk("async_rst_bus_err", 32'(bus_err), 32'd0);
    rd_n = 1'b1; den_n = 1'b1; sys_rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    idle_noise();
    do_ale(1'b1, 20'h002F8, 1'b0, 1'b1);
    do_cmd(1'b1, 1'b1, 20'h002F8, 8'h00, 8'h42, 0);

    repeat (4) tick();
    chk("leftover_strobes", 32'(q_strb.size()), 32'd0);
    chk("leftover_ready_runs", 32'(q_rdy.size()), 32'd0);
    chk("leftover_bus_err", 32'(q_err.size()), 32'd0);
    chk("leftover_read_data", 32'(q_dat.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
